// File: rtl/edge_detection_stream.sv
// Streaming 3x3 binary edge/cleanup filter: one pixel in per cycle, one result per image pixel.
// Two line buffers plus a 3x3 window; zero padding is generated internally at the right/bottom.
module edge_detection_stream #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int MIN_NB = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic mode,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_pixel,
   input  logic in_sof,
   output logic out_valid,
   output logic out_pixel,
   output logic out_sof,
   output logic out_eof,
   output logic busy,
   output logic sof_err
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);
   localparam logic [CW-1:0] C_END  = CW'(IMG_W);
   localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] R_END  = RW'(IMG_H);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAD_COL, PAD_ROW} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;
   logic            r_mode;
   logic            r_sof_err;
   logic            w_ready, w_acc, w_step, w_pix, w_latch, w_err_set;

   logic [IMG_W:0]  r_lb1, r_lb2;
   logic            r_top1, r_mid1, r_bot1, r_top2, r_mid2, r_bot2;
   logic            w_top0, w_mid0, w_bot0;
   logic            w_top_ok, w_bot_ok, w_left_ok, w_right_ok;
   logic            n0, n1, n2, n3, n4, n5, n6, n7, n8;
   logic [3:0]      w_cnt;
   logic            w_res;

   logic            r_out_valid_p1, r_out_pixel_p1, r_out_sof_p1, r_out_eof_p1;

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = (r_state == IDLE) || (r_state == RUN);
      w_acc       = in_valid & w_ready;
      w_step      = 1'b0;
      w_pix       = 1'b0;
      w_latch     = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_acc && in_sof) begin
               w_step      = 1'b1;
               w_pix       = in_pixel;
               w_latch     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_acc) begin
               w_step    = 1'b1;
               w_pix     = in_pixel;
               w_err_set = in_sof;
               if (r_col == C_LAST)
                  w_state_nxt = (r_row == R_LAST) ? PAD_ROW : PAD_COL;
            end
         end
         PAD_COL: begin
            w_step      = 1'b1;
            w_state_nxt = RUN;
         end
         PAD_ROW: begin
            w_step = 1'b1;
            if (r_row == R_END && r_col == C_END)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_col     <= '0;
         r_row     <= '0;
         r_mode    <= 1'b0;
         r_sof_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch)
            r_mode <= mode;
         if (w_err_set)
            r_sof_err <= 1'b1;
         if (w_step) begin
            if (w_state_nxt == IDLE) begin
               r_col <= '0;
               r_row <= '0;
            end else if (r_col == C_END) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // Stage p0: column c of the window comes from the line buffers and the incoming pixel
   assign w_top0 = r_lb2[r_col];
   assign w_mid0 = r_lb1[r_col];
   assign w_bot0 = w_pix;

   always_ff @(posedge clk) begin
      if (w_step) begin
         r_lb2[r_col] <= r_lb1[r_col];
         r_lb1[r_col] <= w_pix;
         r_top2 <= r_top1;
         r_mid2 <= r_mid1;
         r_bot2 <= r_bot1;
         r_top1 <= w_top0;
         r_mid1 <= w_mid0;
         r_bot1 <= w_bot0;
      end
   end

   // Centre is (r-1, c-1); neighbours beyond the image edge are forced to zero.
   assign w_top_ok   = (r_row >= RW'(2));
   assign w_bot_ok   = (r_row != R_END);
   assign w_left_ok  = (r_col >= CW'(2));
   assign w_right_ok = (r_col != C_END);

   assign n0 = r_top2 & w_top_ok & w_left_ok;
   assign n1 = r_top1 & w_top_ok;
   assign n2 = w_top0 & w_top_ok & w_right_ok;
   assign n7 = r_mid2 & w_left_ok;
   assign n8 = r_mid1;
   assign n3 = w_mid0 & w_right_ok;
   assign n6 = r_bot2 & w_bot_ok & w_left_ok;
   assign n5 = r_bot1 & w_bot_ok;
   assign n4 = w_bot0 & w_bot_ok & w_right_ok;

   assign w_cnt = 4'(n0) + 4'(n1) + 4'(n2) + 4'(n3) + 4'(n4) + 4'(n5) + 4'(n6) + 4'(n7);
   assign w_res = r_mode ? (n8 & (w_cnt >= 4'(MIN_NB))) : (n8 & ~(n1 & n3 & n5 & n7));

   // Stage p1: registered result, emitted only for positions with r>=1 and c>=1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid_p1 <= 1'b0;
         r_out_pixel_p1 <= 1'b0;
         r_out_sof_p1   <= 1'b0;
         r_out_eof_p1   <= 1'b0;
      end else begin
         r_out_valid_p1 <= w_step && (r_row != '0) && (r_col != '0);
         r_out_pixel_p1 <= w_step && (r_row != '0) && (r_col != '0) && w_res;
         r_out_sof_p1   <= w_step && (r_row == RW'(1)) && (r_col == CW'(1));
         r_out_eof_p1   <= w_step && (r_row == R_END) && (r_col == C_END);
      end
   end

   assign in_ready  = w_ready;
   assign busy      = (r_state != IDLE);
   assign sof_err   = r_sof_err;
   assign out_valid = r_out_valid_p1;
   assign out_pixel = r_out_pixel_p1;
   assign out_sof   = r_out_sof_p1;
   assign out_eof   = r_out_eof_p1;

endmodule

// File: tb/tb_edge_detection_stream.sv
// Randomised bench for edge_detection_stream (4x4 frames) with a behavioural 3x3 reference model.
module tb_edge_detection_stream;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rst, mode, in_valid, in_ready, in_pixel, in_sof;
   logic out_valid, out_pixel, out_sof, out_eof, busy, sof_err;

   int n_tests = 0;
   int n_fail  = 0;

   bit             frm [H][W];
   logic [2:0]     exp_q[$];
   logic [W*H-1:0] exp_bits;
   logic [W*H-1:0] cap_bits;
   int             cap_idx;
   bit             chk_en;

   edge_detection_stream #(.IMG_W(W), .IMG_H(H), .MIN_NB(NB)) dut (
      .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid), .out_pixel(out_pixel),
      .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic bit getp(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
      return frm[r][c];
   endfunction

   // Reference: apply the rule directly to each image pixel using zero outside the frame
   task automatic build_exp(input bit md);
      exp_bits = '0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int cnt;
            bit res;
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) cnt += int'(getp(r + dr, c + dc));
            if (md)
               res = getp(r, c) && (cnt >= NB);
            else
               res = getp(r, c) && !(getp(r-1, c) && getp(r+1, c) && getp(r, c-1) && getp(r, c+1));
            exp_bits[r*W + c] = res;
            exp_q.push_back({res, (r == 0 && c == 0), (r == H-1 && c == W-1)});
         end
      end
   endtask

   always @(negedge clk) begin
      logic [2:0] e;
      if (!rst && out_valid && chk_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out: out_valid=1 with no expected result pending");
         end else begin
            e = exp_q.pop_front();
            check("out_pix_sof_eof", {29'd0, out_pixel, out_sof, out_eof}, {29'd0, e});
         end
         if (out_sof) cap_idx = 0;
         if (cap_idx < W*H) cap_bits[cap_idx] = out_pixel;
         cap_idx++;
      end
   end

   task automatic send_pixel(input bit p, input bit sof, input bit md, input int gap_pct);
      bit done;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done && guard < 200) begin
         @(negedge clk);
         guard++;
         if ($urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1;
            in_pixel = p;
            in_sof   = sof;
            mode     = md;
            if (in_ready) done = 1'b1;
         end else begin
            in_valid = 1'b0;
            in_pixel = 1'($urandom_range(1));
            in_sof   = 1'b0;
         end
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while (busy && g < 200) begin
         @(negedge clk);
         g++;
      end
      check({name, "_idle"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic run_frame(input string name, input bit md, input int gap, input bit toggle, input int inj);
      build_exp(md);
      for (int i = 0; i < W*H; i++)
         send_pixel(frm[i/W][i%W], (i == 0) || (i == inj),
                    (i == 0 || !toggle) ? md : 1'($urandom_range(1)), gap);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      wait_drain(name);
   endtask

   task automatic fill(input int kind);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (kind)
               0:       frm[r][c] = 1'b1;
               1:       frm[r][c] = (r == 1 && c == 1);
               2:       frm[r][c] = (r >= 1 && r <= 2 && c >= 1 && c <= 2);
               default: frm[r][c] = 1'($urandom_range(1));
            endcase
   endtask

   initial begin
      int er[$];
      int eb[$];
      int i;
      rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0;
      chk_en = 1'b1; cap_idx = 0; cap_bits = '0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_sof_err", 32'(sof_err), 0);
      rst = 1'b0;

      // Test 1: all ones, mode 0
      fill(0);
      run_frame("t1", 1'b0, 0, 1'b0, -1);
      check("t1_model", exp_bits, 16'hF99F);
      check("t1_dut", cap_bits, 16'hF99F);
      check("t1_sof_err", 32'(sof_err), 0);

      // Test 2: single pixel and 2x2 block
      fill(1);
      run_frame("t2a", 1'b0, 0, 1'b0, -1);
      check("t2a_model", exp_bits, 16'h0020);
      check("t2a_dut", cap_bits, 16'h0020);
      run_frame("t2b", 1'b1, 0, 1'b0, -1);
      check("t2b_model", exp_bits, 16'h0000);
      check("t2b_dut", cap_bits, 16'h0000);
      fill(2);
      run_frame("t2c", 1'b1, 0, 1'b0, -1);
      check("t2c_model", exp_bits, 16'h0660);
      check("t2c_dut", cap_bits, 16'h0660);

      // Test 3: handshake pattern with in_valid held high
      fill(3);
      build_exp(1'b0);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            er.push_back(1);
            eb.push_back((r == 0 && c == 0) ? 0 : 1);
         end
         if (r < H-1) begin er.push_back(0); eb.push_back(1); end
      end
      for (int k = 0; k < W+2; k++) begin er.push_back(0); eb.push_back(1); end
      er.push_back(1); eb.push_back(0);
      i = 0;
      for (int k = 0; k < er.size(); k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         mode     = 1'b0;
         in_pixel = (i < W*H) ? frm[i/W][i%W] : 1'b0;
         in_sof   = (i == 0);
         check("t3_in_ready", 32'(in_ready), 32'(er[k]));
         check("t3_busy", 32'(busy), 32'(eb[k]));
         if (in_ready && i < W*H) i++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain("t3");

      // Test 4: all ones with random gaps
      fill(0);
      run_frame("t4", 1'b0, 40, 1'b0, -1);
      check("t4_dut", cap_bits, 16'hF99F);

      // Test 5: reset mid-frame, dropped non-SOF pixels, then a clean frame
      chk_en = 1'b0;
      for (int k = 0; k < 7; k++) send_pixel(1'b1, k == 0, 1'b0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("t5_out_valid", 32'(out_valid), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      exp_q.delete();
      chk_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_pixel = 1'b1; in_sof = 1'b0;
         if (k > 0) check("t5_drop_busy", 32'(busy), 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("t5_drop_busy", 32'(busy), 0);
      fill(0);
      run_frame("t5", 1'b0, 0, 1'b0, -1);
      check("t5_dut", cap_bits, 16'hF99F);

      // Test 6: mode toggled mid-frame and SOF injected on pixel 5
      fill(3);
      check("t6_sof_err_before", 32'(sof_err), 0);
      run_frame("t6a", 1'b0, 20, 1'b1, 5);
      check("t6_sof_err_set", 32'(sof_err), 1);
      fill(3);
      run_frame("t6b", 1'b1, 20, 1'b1, -1);
      check("t6_sof_err_sticky", 32'(sof_err), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_sof_err_cleared", 32'(sof_err), 0);

      // Random frames, modes and gaps
      for (int k = 0; k < 8; k++) begin
         fill(3);
         run_frame("rand", 1'($urandom_range(1)), 30, 1'b1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
